// File: rtl/pipe_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package pipe_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'd0,
    PCSRC_JR  = 2'd1,
    PCSRC_BR  = 2'd2,
    PCSRC_J   = 2'd3
  } pcsrc_e;

  function automatic logic [XLEN-1:0] sext18(input logic [17:0] v);
    return {{(XLEN-18){v[17]}}, v};
  endfunction

endpackage

// File: rtl/pipe_fetch_unit_if.sv
// Control inputs and IF/ID outputs of the fetch stage. The perf counter
// signals exist only when FETCH_PERF_EN is defined.
interface pipe_fetch_unit_if #(parameter int IMEM_AW = 8);
  import pipe_fetch_unit_pkg::*;

  logic              stall;
  logic [1:0]        pcsource;
  logic [XLEN-1:0]   br_base;
  logic [17:0]       imm18;
  logic [27:0]       index28;
  logic [XLEN-1:0]   pc_jr;
  logic              ram_wena;
  logic [IMEM_AW-1:0] ram_waddr;
  logic [ILEN-1:0]   ram_indata;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   if_pc;
  logic [ILEN-1:0]   if_inst;
  logic              if_valid;
  logic [XLEN-1:0]   pc8;

`ifdef FETCH_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_stalls;

  modport master (
    output stall, pcsource, br_base, imm18, index28, pc_jr,
           ram_wena, ram_waddr, ram_indata,
    input  pc, if_pc, if_inst, if_valid, pc8, perf_fetched, perf_stalls
  );
  modport slave (
    input  stall, pcsource, br_base, imm18, index28, pc_jr,
           ram_wena, ram_waddr, ram_indata,
    output pc, if_pc, if_inst, if_valid, pc8, perf_fetched, perf_stalls
  );
`else
  modport master (
    output stall, pcsource, br_base, imm18, index28, pc_jr,
           ram_wena, ram_waddr, ram_indata,
    input  pc, if_pc, if_inst, if_valid, pc8
  );
  modport slave (
    input  stall, pcsource, br_base, imm18, index28, pc_jr,
           ram_wena, ram_waddr, ram_indata,
    output pc, if_pc, if_inst, if_valid, pc8
  );
`endif

endinterface

// File: rtl/pipe_fetch_unit_imem_sync.sv
// Single-clock instruction RAM: one write port, one synchronous read port
// with read enable and a resettable output register.
module imem_sync #(
  parameter int    AW        = 8,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(2**AW)-1];

  // NOTE: the array has no reset so it maps onto block RAM; only the output
  // register is cleared, which also keeps program contents across rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-address write in this cycle is not visible here: read-old.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_fetch_unit.sv
// MIPS IF stage: PC register, next-PC select, synchronous IMEM and IF/ID
// register. Define FETCH_PERF_EN to add the fetched/stalled counters.
module pipe_fetch_unit
  import pipe_fetch_unit_pkg::*;
#(
  parameter int              IMEM_AW      = 8,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter string           INIT_FILE    = ""
) (
  input logic               clk,
  input logic               rst,
  pipe_fetch_unit_if.slave  bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] if_pc_q;
  logic [ILEN-1:0] if_inst_q;
  logic            if_valid_q;
  logic [XLEN-1:0] tgt;
  pcsrc_e          pcsrc;

  assign pcsrc = pcsrc_e'(bus.pcsource);

  // NOTE: tgt gets a default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    tgt = pc_q + 32'd4;
    case (pcsrc)
      PCSRC_SEQ: tgt = pc_q + 32'd4;
      PCSRC_JR:  tgt = bus.pc_jr & ~32'd3;
      PCSRC_BR:  tgt = bus.br_base + sext18(bus.imm18);
      PCSRC_J:   tgt = {bus.br_base[31:28], bus.index28};
      default:   tgt = pc_q + 32'd4;
    endcase
  end

  imem_sync #(
    .AW        (IMEM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.ram_wena),
    .waddr (bus.ram_waddr),
    .wdata (bus.ram_indata),
    .re    (!bus.stall),
    .raddr (pc_q[IMEM_AW+1:2]),
    .rdata (if_inst_q)
  );

  // NOTE: state updates use <= so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q       <= tgt;
      if_pc_q    <= pc_q;
      // Any redirect squashes the word fetched alongside it: one bubble.
      if_valid_q <= (pcsrc == PCSRC_SEQ);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stalls_q  <= '0;
    end else if (bus.stall) begin
      perf_stalls_q  <= perf_stalls_q + 32'd1;
    end else if (pcsrc == PCSRC_SEQ) begin
      perf_fetched_q <= perf_fetched_q + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stalls  = perf_stalls_q;
`endif

  assign bus.pc       = pc_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.if_valid = if_valid_q;
  assign bus.pc8      = if_pc_q + 32'd8;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Bench for pipe_fetch_unit: a reference model checked every cycle plus
// directed literal checks, and a small-IMEM instance for address wrap.
module tb_pipe_fetch_unit;

  localparam logic [31:0] INST_A = 32'h2001_0005;
  localparam logic [31:0] INST_B = 32'h2002_0007;
  localparam logic [31:0] INST_C = 32'h0022_1820;
  localparam logic [31:0] INST_D = 32'h0800_0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_fetch_unit_if #(.IMEM_AW(8)) bus ();
  pipe_fetch_unit_if #(.IMEM_AW(4)) wbus ();

  pipe_fetch_unit #(
    .IMEM_AW(8), .RESET_VECTOR(32'h0000_0040), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  pipe_fetch_unit #(
    .IMEM_AW(4), .RESET_VECTOR(32'h0000_0038), .INIT_FILE("")
  ) dut_wrap (
    .clk(clk), .rst(rst), .bus(wbus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: memory image plus architectural fetch state.
  logic [31:0] m_mem [0:255];
  logic [31:0] m_pc, m_if_pc, m_if_inst, m_fetched, m_stalls;
  logic        m_valid;
  bit          m_live = 0;

  always @(posedge clk) begin
    logic [31:0] rd;
    logic [31:0] nxt;
    rd  = m_mem[m_pc[9:2]];
    nxt = m_pc + 32'd4;
    case (bus.pcsource)
      2'd1: nxt = {bus.pc_jr[31:2], 2'b00};
      2'd2: nxt = bus.br_base + {{14{bus.imm18[17]}}, bus.imm18};
      2'd3: nxt = {bus.br_base[31:28], bus.index28};
      default: nxt = m_pc + 32'd4;
    endcase
    if (rst) begin
      m_pc = 32'h40; m_if_pc = 0; m_if_inst = 0; m_valid = 0;
      m_fetched = 0; m_stalls = 0; m_live = 1;
    end else if (bus.stall) begin
      m_stalls = m_stalls + 1;
    end else begin
      m_if_pc   = m_pc;
      m_if_inst = rd;
      m_valid   = (bus.pcsource == 2'd0);
      if (m_valid) m_fetched = m_fetched + 1;
      m_pc      = nxt;
    end
    if (bus.ram_wena) m_mem[bus.ram_waddr] = bus.ram_indata;
  end

  always @(posedge clk) begin
    #1;
    if (m_live) begin
      check("model_pc", bus.pc, m_pc);
      check("model_if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
      if (m_valid) begin
        check("model_if_pc", bus.if_pc, m_if_pc);
        check("model_if_inst", bus.if_inst, m_if_inst);
        check("model_pc8", bus.pc8, m_if_pc + 32'd8);
      end
`ifdef FETCH_PERF_EN
      check("model_perf_fetched", bus.perf_fetched, m_fetched);
      check("model_perf_stalls", bus.perf_stalls, m_stalls);
`endif
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, bus.pc, 32'h40);
    check({tag, "_if_valid"}, {31'd0, bus.if_valid}, 32'd0);
    check({tag, "_if_pc"}, bus.if_pc, 32'd0);
    check({tag, "_if_inst"}, bus.if_inst, 32'd0);
`ifdef FETCH_PERF_EN
    check({tag, "_perf_fetched"}, bus.perf_fetched, 32'd0);
    check({tag, "_perf_stalls"}, bus.perf_stalls, 32'd0);
`endif
  endtask

  initial begin
    bus.stall = 0; bus.pcsource = 0; bus.br_base = 0; bus.imm18 = 0;
    bus.index28 = 0; bus.pc_jr = 0; bus.ram_wena = 0; bus.ram_waddr = 0; bus.ram_indata = 0;
    wbus.stall = 0; wbus.pcsource = 0; wbus.br_base = 0; wbus.imm18 = 0;
    wbus.index28 = 0; wbus.pc_jr = 0; wbus.ram_wena = 0; wbus.ram_waddr = 0; wbus.ram_indata = 0;
    rst = 1;

    // Program load during reset.
    for (int i = 0; i < 256; i++) begin
      bus.ram_wena   = 1;
      bus.ram_waddr  = 8'(i);
      bus.ram_indata = (i == 16) ? INST_A : (i == 17) ? INST_B : 32'hC0DE_0000 + 32'(i);
      wbus.ram_wena   = (i < 16);
      wbus.ram_waddr  = 4'(i);
      wbus.ram_indata = 32'hBEEF_0000 + 32'(i);
      step();
    end
    bus.ram_wena = 0; wbus.ram_wena = 0;
    check_reset_state("reset");
    check("reset_pc8", bus.pc8, 32'd8);
    check("wrap_reset_pc", wbus.pc, 32'h38);

    // Stall and reset on the same edge: reset wins.
    bus.stall = 1;
    step();
    check_reset_state("rst_stall");
    bus.stall = 0;

    rst = 0;
    step();
    check("first_if_pc", bus.if_pc, 32'h40);
    check("first_if_inst", bus.if_inst, INST_A);
    check("first_if_valid", {31'd0, bus.if_valid}, 32'd1);
    check("first_pc", bus.pc, 32'h44);
    check("wrap_if_pc0", wbus.if_pc, 32'h38);
    check("wrap_if_inst0", wbus.if_inst, 32'hBEEF_000E);
    step();
    check("second_if_inst", bus.if_inst, INST_B);
    check("second_pc8", bus.pc8, 32'h4C);
    check("second_pc", bus.pc, 32'h48);
    check("wrap_if_inst1", wbus.if_inst, 32'hBEEF_000F);
    check("wrap_pc", wbus.pc, 32'h40);

    // Three-cycle stall with an IMEM write to the held address.
    bus.stall = 1; bus.ram_wena = 1; bus.ram_waddr = 8'h12; bus.ram_indata = INST_C;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.ram_wena = 0;
      if (k == 0) begin
        check("wrap_if_pc_wrapped", wbus.if_pc, 32'h40);
        check("wrap_if_inst_word0", wbus.if_inst, 32'hBEEF_0000);
      end
      check("stall_pc", bus.pc, 32'h48);
      check("stall_if_pc", bus.if_pc, 32'h44);
      check("stall_if_inst", bus.if_inst, INST_B);
    end
    bus.stall = 0;
    step();
    check("post_stall_if_pc", bus.if_pc, 32'h48);
    check("post_stall_if_inst", bus.if_inst, INST_C);
    check("post_stall_pc", bus.pc, 32'h4C);
`ifdef FETCH_PERF_EN
    check("perf_stalls_3", bus.perf_stalls, 32'd3);
    check("perf_fetched_3", bus.perf_fetched, 32'd3);
`endif

    // Branch with a negative offset.
    bus.pcsource = 2'd2; bus.br_base = 32'h100; bus.imm18 = 18'h3FFF0;
    step();
    check("br_pc", bus.pc, 32'hF0);
    check("br_bubble", {31'd0, bus.if_valid}, 32'd0);
    bus.pcsource = 2'd0;
    step();
    check("br_if_pc", bus.if_pc, 32'hF0);
    check("br_if_valid", {31'd0, bus.if_valid}, 32'd1);
    check("br_if_inst", bus.if_inst, 32'hC0DE_003C);

    // Jump keeps the region bits of br_base.
    bus.pcsource = 2'd3; bus.br_base = 32'hA000_0004; bus.index28 = 28'h000_0120;
    step();
    check("j_pc", bus.pc, 32'hA000_0120);
    check("j_bubble", {31'd0, bus.if_valid}, 32'd0);
    bus.pcsource = 2'd0;
    step();
    check("j_if_pc", bus.if_pc, 32'hA000_0120);
    check("j_if_inst", bus.if_inst, 32'hC0DE_0048);

    // jr then an immediate branch: both squash.
    bus.pcsource = 2'd1; bus.pc_jr = 32'h203;
    step();
    check("jr_pc", bus.pc, 32'h200);
    check("jr_bubble", {31'd0, bus.if_valid}, 32'd0);
    bus.pcsource = 2'd2; bus.br_base = 32'h10; bus.imm18 = 18'h00008;
    step();
    check("br2_pc", bus.pc, 32'h18);
    check("br2_bubble", {31'd0, bus.if_valid}, 32'd0);
    bus.pcsource = 2'd0;
    step();
    check("br2_if_pc", bus.if_pc, 32'h18);
    check("br2_if_inst", bus.if_inst, 32'hC0DE_0006);

    // A redirect presented during a stall takes effect on release.
    bus.stall = 1; bus.pcsource = 2'd1; bus.pc_jr = 32'h300;
    step();
    check("held_redirect_pc", bus.pc, 32'h1C);
    bus.stall = 0;
    step();
    check("released_redirect_pc", bus.pc, 32'h300);
    bus.pcsource = 2'd0;

    // Same-address write and read: the fetch returns the old word.
    bus.ram_wena = 1; bus.ram_waddr = 8'hC0; bus.ram_indata = INST_D;
    step();
    bus.ram_wena = 0;
    check("rdw_old_inst", bus.if_inst, 32'hC0DE_00C0);
    bus.pcsource = 2'd1; bus.pc_jr = 32'h300;
    step();
    bus.pcsource = 2'd0;
    step();
    check("rdw_new_inst", bus.if_inst, INST_D);

    // Reset arriving in the middle of a stall.
    bus.stall = 1;
    step();
    step();
    rst = 1;
    step();
    check_reset_state("mid_stall_rst");
    rst = 0; bus.stall = 0;
    step();
    check("after_rst_if_pc", bus.if_pc, 32'h40);
    check("after_rst_if_inst", bus.if_inst, INST_A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
